// File: rtl/jam_pkg.sv
// jam_pkg: shared widths, table depth and host FSM state encoding for the JAM host.
package jam_pkg;
    localparam int COST_W      = 7;
    localparam int SUM_W       = 10;
    localparam int MATCH_W     = 4;
    localparam int IDX_W       = 3;
    localparam int TABLE_DEPTH = 64;

    typedef enum logic [1:0] {LOAD, RUN, RESULT} state_t;
endpackage

// File: rtl/jam_cost_table.sv
// jam_cost_table: 64-entry cost store, synchronous write and combinational read, no reset.
module jam_cost_table
    import jam_pkg::*;
(
    input  logic                 CLK,
    input  logic                 we,
    input  logic [2*IDX_W-1:0]   waddr,
    input  logic [COST_W-1:0]    wdata,
    input  logic [2*IDX_W-1:0]   raddr,
    output logic [COST_W-1:0]    rdata
);
    logic [COST_W-1:0] mem [TABLE_DEPTH];

    always_ff @(posedge CLK)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/jam_host.sv
// jam_host: loads the cost table, runs the JAM engine and returns its result.
// Optional RUN timeout is compiled in with JAM_HOST_TIMEOUT_EN.
module jam_host
    import jam_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 21
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 load_valid,
    input  logic [COST_W-1:0]    load_data,
    output logic                 load_ready,
    output logic                 jam_rst,
    input  logic [IDX_W-1:0]     W,
    input  logic [IDX_W-1:0]     J,
    output logic [COST_W-1:0]    Cost,
    input  logic                 Valid,
    input  logic [SUM_W-1:0]     MinCost,
    input  logic [MATCH_W-1:0]   MatchCount,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SUM_W-1:0]     res_min_cost,
    output logic [MATCH_W-1:0]   res_match_count,
    output logic                 res_timeout
);
    state_t               state, next_state;
    logic [2*IDX_W-1:0]   idx;
    logic                 accept, tmo;

    assign load_ready = (state == LOAD);
    assign accept     = load_valid && load_ready;

    jam_cost_table u_table (
        .CLK   (CLK),
        .we    (accept),
        .waddr (idx),
        .wdata (load_data),
        .raddr ({W, J}),
        .rdata (Cost)
    );

`ifdef JAM_HOST_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK)
        if (RST || state != RUN) cnt <= '0;
        else if (cnt != '1)      cnt <= cnt + 1'b1;

    assign tmo = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Parameters kept for a uniform interface; without the counter the abort never fires.
    assign tmo = (TIMEOUT_CYCLES < 0) && (CNT_W < 0);
`endif

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (accept && idx == 6'(TABLE_DEPTH - 1)) next_state = RUN;
            RUN:     if (Valid || tmo)                           next_state = RESULT;
            RESULT:  if (res_ready)                              next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= LOAD;
            idx             <= '0;
            jam_rst         <= 1'b1;
            res_valid       <= 1'b0;
            res_min_cost    <= '0;
            res_match_count <= '0;
            res_timeout     <= 1'b0;
        end else begin
            state     <= next_state;
            jam_rst   <= (next_state != RUN);
            res_valid <= (next_state == RESULT);
            if (accept) idx <= idx + 1'b1;
            // Valid has priority over a timeout landing in the same cycle.
            if (state == RUN && Valid) begin
                res_min_cost    <= MinCost;
                res_match_count <= MatchCount;
                res_timeout     <= 1'b0;
            end else if (state == RUN && tmo) begin
                res_min_cost    <= '1;
                res_match_count <= '0;
                res_timeout     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jam_host.sv
// tb_jam_host: directed self-checking bench for jam_host.
module tb_jam_host;
    logic       CLK = 0;
    logic       RST = 1;
    logic       load_valid = 0;
    logic [6:0] load_data = 0;
    logic       load_ready, jam_rst;
    logic [2:0] W = 0, J = 0;
    logic [6:0] Cost;
    logic       Valid = 0;
    logic [9:0] MinCost = 0;
    logic [3:0] MatchCount = 0;
    logic       res_valid, res_ready = 0, res_timeout;
    logic [9:0] res_min_cost;
    logic [3:0] res_match_count;
    int n_cmp = 0, n_fail = 0;

    always #5 CLK = ~CLK;

    jam_host #(.TIMEOUT_CYCLES(100), .CNT_W(21)) dut (
        .CLK(CLK), .RST(RST), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .jam_rst(jam_rst), .W(W), .J(J), .Cost(Cost),
        .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .res_valid(res_valid), .res_ready(res_ready), .res_min_cost(res_min_cost),
        .res_match_count(res_match_count), .res_timeout(res_timeout)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // mode 0: table[k]=k, 1: diagonal 0 / off-diagonal 10, 2: 127-k, 3: constant 5
    task automatic load_table(input int mode, input int n);
        for (int k = 0; k < n; k++) begin
            load_valid = 1;
            load_data  = mode == 0 ? 7'(k) : mode == 1 ? ((k / 8 == k % 8) ? 7'd0 : 7'd10) :
                         mode == 2 ? 7'(127 - k) : 7'd5;
            step();
        end
        load_valid = 0;
    endtask

    task automatic finish_run(input logic [9:0] mc, input logic [3:0] cnt);
        MinCost = mc; MatchCount = cnt; Valid = 1;
        step();
        Valid = 0; res_ready = 1;
        step();
        res_ready = 0;
    endtask

    task automatic test_reset();
        RST = 1;
        step();
        RST = 0;
        n_cmp++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
        n_cmp++; if (jam_rst !== 1'b1) begin n_fail++; $display("FAIL reset_jam_rst: got %b want 1", jam_rst); end
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        n_cmp++; if (res_min_cost !== 10'd0 || res_match_count !== 4'd0 || res_timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_results: got %0d/%0d/%b want 0/0/0", res_min_cost, res_match_count, res_timeout); end
    endtask

    task automatic test_toggle_load();
        int acc = 0;
        for (int c = 0; c < 200 && load_ready; c++) begin
            load_valid = (c % 2 == 0);
            load_data  = 7'(c);
            if (load_valid && load_ready) acc++;
            step();
        end
        n_cmp++; if (acc !== 64) begin n_fail++; $display("FAIL toggle_beats: got %0d want 64", acc); end
        n_cmp++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL toggle_load_ready: got %b want 0", load_ready); end
        n_cmp++; if (jam_rst !== 1'b0) begin n_fail++; $display("FAIL toggle_jam_rst: got %b want 0", jam_rst); end
        for (int c = 0; c < 4; c++) begin
            load_valid = (c % 2 == 0);
            step();
        end
        load_valid = 0;
        n_cmp++; if (load_ready !== 1'b0 || jam_rst !== 1'b0) begin
            n_fail++; $display("FAIL run_ignores_beats: got ready=%b jam_rst=%b want 0/0", load_ready, jam_rst); end
        finish_run(10'd7, 4'd2);
    endtask

    task automatic test_cost_and_result();
        load_table(0, 64);
        W = 3; J = 5; #1;
        n_cmp++; if (Cost !== 7'd29) begin n_fail++; $display("FAIL cost_3_5: got %0d want 29", Cost); end
        W = 7; J = 7; #1;
        n_cmp++; if (Cost !== 7'd63) begin n_fail++; $display("FAIL cost_7_7: got %0d want 63", Cost); end
        W = 0; J = 0; #1;
        n_cmp++; if (Cost !== 7'd0) begin n_fail++; $display("FAIL cost_0_0: got %0d want 0", Cost); end
        MinCost = 10'd123; MatchCount = 4'd4; Valid = 1;
        step();
        Valid = 0; MinCost = 10'd0; MatchCount = 4'd0;
        n_cmp++; if (jam_rst !== 1'b1) begin n_fail++; $display("FAIL result_jam_rst: got %b want 1", jam_rst); end
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (res_valid !== 1'b1 || res_min_cost !== 10'd123 || res_match_count !== 4'd4 || res_timeout !== 1'b0) begin
                n_fail++; $display("FAIL result_hold_%0d: got %b/%0d/%0d/%b want 1/123/4/0", c, res_valid, res_min_cost, res_match_count, res_timeout); end
            step();
        end
        res_ready = 1;
        step();
        res_ready = 0;
        n_cmp++; if (res_valid !== 1'b0 || load_ready !== 1'b1) begin
            n_fail++; $display("FAIL result_accept: got valid=%b ready=%b want 0/1", res_valid, load_ready); end
        n_cmp++; if (res_min_cost !== 10'd123 || res_match_count !== 4'd4) begin
            n_fail++; $display("FAIL result_persist: got %0d/%0d want 123/4", res_min_cost, res_match_count); end
        W = 3; J = 5; #1;
        n_cmp++; if (Cost !== 7'd29) begin n_fail++; $display("FAIL cost_in_load: got %0d want 29", Cost); end
        Valid = 1;
        step();
        Valid = 0;
        n_cmp++; if (load_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++; $display("FAIL valid_in_load: got ready=%b valid=%b want 1/0", load_ready, res_valid); end
    endtask

    task automatic test_diagonal();
        int sum = 0, ways = 1, rmin, nm;
        load_table(1, 64);
        n_cmp++; if (jam_rst !== 1'b0) begin n_fail++; $display("FAIL diag_jam_rst: got %b want 0", jam_rst); end
        for (int w = 0; w < 8; w++) begin
            rmin = 1000; nm = 0;
            for (int j = 0; j < 8; j++) begin
                W = 3'(w); J = 3'(j); #1;
                if (int'(Cost) < rmin) begin rmin = int'(Cost); nm = 1; end
                else if (int'(Cost) == rmin) nm++;
            end
            sum += rmin; ways *= nm;
            step();
        end
        MinCost = 10'(sum); MatchCount = 4'(ways); Valid = 1;
        step();
        Valid = 0;
        for (int t = 0; t < 10 && !res_valid; t++) step();
        n_cmp++; if (res_valid !== 1'b1 || res_min_cost !== 10'd0 || res_match_count !== 4'd1 || res_timeout !== 1'b0) begin
            n_fail++; $display("FAIL diag_result: got %b/%0d/%0d/%b want 1/0/1/0", res_valid, res_min_cost, res_match_count, res_timeout); end
        res_ready = 1;
        step();
        res_ready = 0;
    endtask

    task automatic test_rst_mid();
        load_table(2, 64);
        for (int c = 0; c < 49; c++) step();
        n_cmp++; if (jam_rst !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_run: got %b want 0", jam_rst); end
        RST = 1;
        step();
        RST = 0;
        n_cmp++; if (load_ready !== 1'b1 || jam_rst !== 1'b1 || res_valid !== 1'b0 || res_min_cost !== 10'd0) begin
            n_fail++; $display("FAIL rst_mid_state: got %b/%b/%b/%0d want 1/1/0/0", load_ready, jam_rst, res_valid, res_min_cost); end
        W = 0; J = 1; #1;
        n_cmp++; if (Cost !== 7'd126) begin n_fail++; $display("FAIL table_survives_rst: got %0d want 126", Cost); end
        load_table(3, 10);
        RST = 1;
        step();
        RST = 0;
        load_table(0, 63);
        n_cmp++; if (load_ready !== 1'b1 || jam_rst !== 1'b1) begin
            n_fail++; $display("FAIL reload_63: got ready=%b jam_rst=%b want 1/1", load_ready, jam_rst); end
        load_table(0, 1);
        n_cmp++; if (load_ready !== 1'b0 || jam_rst !== 1'b0) begin
            n_fail++; $display("FAIL reload_64: got ready=%b jam_rst=%b want 0/0", load_ready, jam_rst); end
        W = 7; J = 0; #1;
        n_cmp++; if (Cost !== 7'd56) begin n_fail++; $display("FAIL reload_cost_7_0: got %0d want 56", Cost); end
        W = 1; J = 1; #1;
        n_cmp++; if (Cost !== 7'd9) begin n_fail++; $display("FAIL reload_cost_1_1: got %0d want 9", Cost); end
        finish_run(10'd55, 4'd3);
        n_cmp++; if (res_min_cost !== 10'd55 || res_match_count !== 4'd3 || load_ready !== 1'b1) begin
            n_fail++; $display("FAIL reload_result: got %0d/%0d/%b want 55/3/1", res_min_cost, res_match_count, load_ready); end
    endtask

`ifdef JAM_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int t = 0;
        load_table(0, 64);
        while (!res_valid && t < 200) begin step(); t++; end
        n_cmp++; if (t !== 100) begin n_fail++; $display("FAIL timeout_cycles: got %0d want 100", t); end
        n_cmp++; if (res_timeout !== 1'b1 || res_min_cost !== 10'h3FF || res_match_count !== 4'd0) begin
            n_fail++; $display("FAIL timeout_result: got %b/%0h/%0d want 1/3ff/0", res_timeout, res_min_cost, res_match_count); end
        res_ready = 1;
        step();
        res_ready = 0;
        load_table(0, 64);
        finish_run(10'd12, 4'd1);
        n_cmp++; if (res_timeout !== 1'b0 || res_min_cost !== 10'd12) begin
            n_fail++; $display("FAIL timeout_cleared: got %b/%0d want 0/12", res_timeout, res_min_cost); end
    endtask
`endif

    initial begin
        test_reset();
        test_toggle_load();
        test_cost_and_result();
        test_diagonal();
        test_rst_mid();
`ifdef JAM_HOST_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
